// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage sequencer for the HI/LO multiply/divide resource.
// It accepts one MDU op per idle cycle and models the fixed latency of
// multiply and divide. It owns HI/LO and drives start/busy and the
// D-stage stall request.
//
// Handshake: an op is taken when req_valid=1 in a cycle where busy=0.
// mult/multu/div/divu raise start (combinational) in that cycle. busy then
// stays high for exactly MULT_CYCLES or DIV_CYCLES cycles. The new HI/LO
// are visible in the first cycle after that, when busy=0 again. Ops that
// arrive while busy=1 are ignored.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid, op     live E-stage MDU op (1 mult, 2 multu, 3 div, 4 divu,
//                     5 mthi, 6 mtlo; 0/7 no-op)
//   rs_val, rt_val    forwarded operands, sampled only on the start edge
//   d_uses_mdu        D-stage instruction touches HI/LO
//   hi, lo            architectural HI/LO registers
//   start, busy       op accepted this cycle / latency in progress
//   stall             D-stage stall request
//   dbg_state         FSM state (0 IDLE, 1 RUN) for checkers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_mdu,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        commit;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_ok;

  logic        is_mul, is_div, mt_hi, mt_lo;
  logic [63:0] prod;
  logic        div_zero, neg_q, neg_r;
  logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

  assign is_mul = (op == 3'd1) || (op == 3'd2);
  assign is_div = (op == 3'd3) || (op == 3'd4);
  assign start  = req_valid && (is_mul || is_div) && (state == IDLE);
  assign mt_hi  = req_valid && (op == 3'd5) && (state == IDLE);
  assign mt_lo  = req_valid && (op == 3'd6) && (state == IDLE);
  assign busy   = (state == RUN);
  assign stall  = d_uses_mdu && (start || busy);
  assign dbg_state = (state == RUN);

  // The low 64 bits of a product of 64-bit extended operands equal the
  // signed (sign-extended) or unsigned (zero-extended) 32x32 product.
  always_comb begin
    if (op == 3'd1)
      prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    else
      prod = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // A single unsigned divider on operand magnitudes serves both div and divu.
  // Fix-ups: the quotient is negative when the operand signs differ, and the
  // remainder takes the dividend's sign. 0x80000000/-1 falls out naturally:
  // the magnitude is 0x80000000 and its negation wraps to 0x80000000.
  // A zero divisor is replaced by 1 so the divider never sees zero. That
  // result is never committed.
  always_comb begin
    div_zero = (rt_val == 32'd0);
    neg_q    = (op == 3'd3) && (rs_val[31] ^ rt_val[31]);
    neg_r    = (op == 3'd3) && rs_val[31];
    mag_a    = ((op == 3'd3) && rs_val[31]) ? -rs_val : rs_val;
    mag_b    = ((op == 3'd3) && rt_val[31]) ? -rt_val : rt_val;
    if (div_zero) mag_b = 32'd1;
    uq       = mag_a / mag_b;
    ur       = mag_a % mag_b;
    quo      = neg_q ? -uq : uq;
    rem      = neg_r ? -ur : ur;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        pend_hi <= is_mul ? prod[63:32] : rem;
        pend_lo <= is_mul ? prod[31:0]  : quo;
        pend_ok <= is_mul || !div_zero;
      end
      // Commit happens only in RUN and mt* only in IDLE, so they never collide.
      if (commit && pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (mt_hi) hi <= rs_val;
      if (mt_lo) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        d_uses_mdu;
  logic [31:0] hi, lo;
  logic        start, busy, stall, dbg_state;

  int n_pass = 0;
  int n_total = 0;

  // Reference HI/LO, updated from the instruction rules only.
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .d_uses_mdu(d_uses_mdu),
    .hi(hi), .lo(lo), .start(start), .busy(busy), .stall(stall),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Issuing an op while busy is a protocol error.
  always @(negedge clk) begin
    if (!reset && req_valid && busy && op >= 3'd1 && op <= 3'd6) begin
      n_total++;
      $display("FAIL protocol: op %0d issued while busy", op);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ch,
                                          input logic [31:0] cl);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {ch, cl};
    case (o)
      3'd1: res = 64'(sa * sb);
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: if (b != 0) begin
              q = sa / sb;
              r = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      3'd4: if (b != 0) res = {a % b, a / b};
      3'd5: res = {a, cl};
      3'd6: res = {ch, a};
      default: res = {ch, cl};
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 5;
    if (o == 3'd3 || o == 3'd4) return 10;
    return 0;
  endfunction

  // Drive one op (caller is just after a posedge), then wait out busy.
  // Returns in the first cycle with busy=0 and reports busy length.
  task automatic run_op(input string name, input logic v, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, output int nbusy);
    logic exp_start;
    exp_start = v && ref_lat(o) != 0;
    req_valid = v; op = o; rs_val = a; rt_val = b;
    #1;
    chk({name, " start"}, 64'(start), 64'(exp_start));
    tick();
    req_valid = 1'b0; op = 3'd0;
    rs_val = $urandom; rt_val = $urandom;   // operands must not be resampled
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      tick();
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nb;
    logic [63:0] e;
    vecs[0] = '{"mult -1*2",     3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu",         3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"divu 7/2",      3'd4, 32'd7,        32'd2, 32'd1,        32'd3,        10};
    vecs[3] = '{"div -7/2",      3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{"div ovf",       3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,  32'h80000000, 10};
    vecs[5] = '{"div 7/-2",      3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,  32'hFFFFFFFD, 10};
    vecs[6] = '{"multu 2^32",    3'd2, 32'h00010000, 32'h00010000, 32'd1, 32'd0,       5};
    vecs[7] = '{"mult neg*neg",  3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 32'd15,      5};

    reset = 1'b1; req_valid = 1'b0; op = 3'd0; rs_val = 0; rt_val = 0; d_uses_mdu = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset start", 64'(start), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    tick();

    // ---- table-driven directed vectors ----
    foreach (vecs[i]) begin
      run_op(vecs[i].name, 1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, nb);
      chk({vecs[i].name, " busy_len"}, 64'(nb), 64'(vecs[i].exp_busy));
      chk({vecs[i].name, " hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      chk({vecs[i].name, " lo"}, 64'(lo), 64'(vecs[i].exp_lo));
    end

    // ---- divide by zero leaves HI/LO alone ----
    run_op("mthi", 1'b1, 3'd5, 32'h11, 32'd0, nb);
    chk("mthi busy_len", 64'(nb), 64'd0);
    chk("mthi hi", 64'(hi), 64'h11);
    run_op("mtlo", 1'b1, 3'd6, 32'h22, 32'd0, nb);
    chk("mtlo lo", 64'(lo), 64'h22);
    run_op("div0", 1'b1, 3'd3, 32'd1234, 32'd0, nb);
    chk("div0 busy_len", 64'(nb), 64'd10);
    chk("div0 hi", 64'(hi), 64'h11);
    chk("div0 lo", 64'(lo), 64'h22);

    // ---- stall timing with mflo in D ----
    d_uses_mdu = 1'b1;
    req_valid = 1'b1; op = 3'd1; rs_val = 32'd6; rt_val = 32'd7;
    #1;
    chk("stall cyc0", 64'(stall), 64'd1);
    tick();
    req_valid = 1'b0; op = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("stall cyc%0d", c), 64'(stall), 64'd1);
      tick();
    end
    #1;
    chk("stall cyc6", 64'(stall), 64'd0);
    chk("stall cyc6 lo", 64'(lo), 64'd42);
    d_uses_mdu = 1'b0;

    // ---- mthi: immediate, no busy ----
    req_valid = 1'b1; op = 3'd5; rs_val = 32'hABCD;
    #1;
    chk("mthi2 start", 64'(start), 64'd0);
    tick();
    req_valid = 1'b0; op = 3'd0;
    chk("mthi2 hi", 64'(hi), 64'hABCD);
    chk("mthi2 busy", 64'(busy), 64'd0);
    tick();

    // ---- back-to-back: next start accepted in commit+1 cycle ----
    run_op("b2b a", 1'b1, 3'd2, 32'd3, 32'd5, nb);
    run_op("b2b b", 1'b1, 3'd2, 32'd4, 32'd5, nb);
    chk("b2b busy_len", 64'(nb), 64'd5);
    chk("b2b lo", 64'(lo), 64'd20);

    // ---- reset during a divide ----
    req_valid = 1'b1; op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    req_valid = 1'b0; op = 3'd0;
    tick(); tick(); tick();           // now in cycle 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_run busy", 64'(busy), 64'd0);
    chk("rst_run hi", 64'(hi), 64'd0);
    chk("rst_run lo", 64'(lo), 64'd0);
    run_op("after rst", 1'b1, 3'd1, 32'd3, 32'd4, nb);
    chk("after rst busy_len", 64'(nb), 64'd5);
    chk("after rst lo", 64'(lo), 64'd12);
    chk("after rst hi", 64'(hi), 64'd0);
    // Pending result of the aborted divide must not appear later.
    tick(); tick();
    chk("after rst hold lo", 64'(lo), 64'd12);

    // ---- randomized ops against the reference model ----
    m_hi = hi; m_lo = lo;
    for (int k = 0; k < 60; k++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      logic v;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      v = ($urandom_range(0, 5) != 0);
      e = v ? ref_res(o, a, b, m_hi, m_lo) : {m_hi, m_lo};
      exp_q.push_back(e);
      run_op($sformatf("rnd%0d", k), v, o, a, b, nb);
      chk($sformatf("rnd%0d op%0d busy_len", k, o), 64'(nb), 64'(v ? ref_lat(o) : 0));
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d op%0d hilo", k, o), {hi, lo}, e);
      m_hi = e[63:32]; m_lo = e[31:0];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
